nn_frame_packer: RTL and testbench
==================================

Name: nn_frame_packer

Overview:
- Upstream front-end of the nn inference core.
- Accepts an 8-bit grayscale pixel stream, one 16x16 frame at a time, and binarises each pixel against a threshold.
- Packs the binarised pixels into the NI-bit xi vector and runs the start/ack/done handshake with nn.
- Returns the predicted class on a valid/ready result interface.

Parameters:
- NI, 256, pixels per frame; width of xi.
- PW, 8, input pixel width.
- CW, 4, class width; equals $clog2(10).
- THRESH, 128, binarisation threshold: bit = (pix_data >= THRESH).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_valid  in  1  pixel beat valid.
- pix_data  in  PW  grayscale pixel, raster order (row 0 col 0 first).
- pix_last  in  1  marks the final pixel of a frame.
- pix_ready  out  1  packer accepts a beat this cycle.
- nn_xi  out  NI  packed binary frame to nn.xi.
- nn_start  out  1  to nn.start.
- nn_ack  in  1  from nn.ack.
- nn_done  in  1  from nn.done.
- nn_yi  in  CW  from nn.yi.
- res_valid  out  1  result available.
- res_class  out  CW  predicted digit, 0..9.
- res_ready  in  1  consumer accepts the result.
- frame_err  out  1  one-cycle pulse when a malformed frame is dropped.

Behaviour:
- Reset values: pix_ready=0, nn_xi=0, nn_start=0, res_valid=0, res_class=0, frame_err=0, pix_cnt=0, state=FILL.
- pix_ready rises on the first cycle after rst deasserts.
- A beat transfers when pix_valid && pix_ready.
- Packing rule: nn_xi <= {nn_xi[NI-2:0], bit}. The first pixel ends at nn_xi[NI-1]; this matches the MSB-first binary memory format.
- State FILL:
  - pix_ready=1; each beat shifts in one bit and increments pix_cnt (8-bit for NI=256).
  - Beat with pix_cnt==NI-1 and pix_last=1: go to START, pix_cnt <= 0.
  - Beat with pix_last=1 and pix_cnt!=NI-1 (short frame): pulse frame_err, pix_cnt <= 0, stay in FILL.
  - Beat with pix_cnt==NI-1 and pix_last=0 (long frame): pulse frame_err, pix_cnt <= 0, stay in FILL. Later beats are treated as a new frame.
- State START:
  - pix_ready=0, nn_start=1.
  - nn_start is held until nn_ack is sampled high. On that edge nn_start <= 0; go to WAIT_DONE.
- State WAIT_DONE:
  - nn_start=0.
  - On the first cycle nn_done is high: res_class <= nn_yi, res_valid <= 1; go to RESULT.
  - nn_done already high at entry is accepted immediately.
- State RESULT:
  - res_valid=1 and res_class held stable.
  - On res_valid && res_ready: res_valid <= 0; go to FILL, where pix_ready rises the next cycle.
- nn_xi is stable from START entry until FILL re-entry.
- Latency: last pixel beat to nn_start high is 1 cycle. done sampled to res_valid is 1 cycle.
- Back-pressure: pixels are stalled (pix_ready=0) for the whole START/WAIT_DONE/RESULT period. There is no overlap in the base build.
- Reset mid-operation (any state): next edge forces all reset values; a partial frame is discarded; nn_start drops at that edge.
- nn_ack or nn_done high outside their states is ignored.

Optional Feature:
- Macro NN_FRAME_PACKER_LATCNT_EN.
- Defined:
  - Adds output lat_cycles [15:0]: cycles from nn_start assertion to nn_done sampling.
  - Counter clears on START entry, increments each cycle in START/WAIT_DONE, and saturates at 16'hFFFF.
  - Value is held while res_valid=1 and is reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package nn_pkg:
  - constants NI=256, PW=8, CW=4, NCLASS=10;
  - state enum {FILL, START, WAIT_DONE, RESULT}.
- One sub-module, nn_pix_shreg: binarise-and-shift register with counter and last-check, emitting a frame_full strobe and an err strobe.
- The FSM and handshake stay in the top.

Test Plan:
- Reset then 256 beats all 8'hFF, pix_last on beat 256 -> nn_xi=all ones; nn_start high 1 cycle after last beat; nn_yi=4'd7 with done -> res_valid, res_class=7.
- Alternating pixels 8'd200/8'd50 starting with 200 -> nn_xi = {128{2'b10}}; threshold edge: pixel 8'd128 -> 1, 8'd127 -> 0.
- pix_last on beat 100 -> frame_err pulses once; no nn_start; the next clean 256-beat frame is processed normally.
- nn_ack delayed 5 cycles and nn_done 40 cycles later, with res_ready low for 3 cycles -> nn_start held exactly until ack; res_class stable while res_valid; pix_ready stays 0 until the handshake completes.
- rst asserted in WAIT_DONE -> nn_start/res_valid 0 after the edge; pix_cnt 0; a late nn_done is ignored; a new frame gives the correct result. With LATCNT_EN, lat_cycles=45 for the delay case.

Source files
------------

// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg
// Shared constants and types for the nn front-end (frame packer) and the
// inference core it feeds.
//   NI      pixels per frame, width of the packed xi vector
//   PW      grayscale pixel width
//   NCLASS  number of output classes (digits 0..9)
//   CW      class index width, wide enough for NCLASS
//   state_t packer control states
// ---------------------------------------------------------------------------
package nn_pkg;

    localparam int NI         = 256;
    localparam int PW         = 8;
    localparam int NCLASS     = 10;
    localparam int CW         = $clog2(NCLASS);
    localparam int THRESH_DEF = 128;

    // FILL: collecting pixels; START: nn_start raised, waiting for ack;
    // WAIT_DONE: core busy; RESULT: class presented to the consumer.
    typedef enum logic [1:0] {
        FILL      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2,
        RESULT    = 2'd3
    } state_t;

endpackage

// File: rtl/nn_frame_packer_if.sv
// ---------------------------------------------------------------------------
// nn_frame_packer_if
// Bundles the three interfaces of the frame packer:
//   pixel stream : pix_valid, pix_data, pix_last  -> packer, pix_ready <- packer
//   nn core      : nn_xi, nn_start                -> core,   nn_ack, nn_done, nn_yi <- core
//   result       : res_valid, res_class           -> consumer, res_ready <- consumer
//   status       : frame_err one-cycle pulse on a dropped malformed frame
// Modports:
//   master : the packer side (drives pix_ready, nn_*, res_*, frame_err)
//   slave  : the environment side (pixel source, nn core, result consumer)
// Optional macro NN_FRAME_PACKER_LATCNT_EN adds lat_cycles[15:0], the
// nn_start-to-nn_done latency of the last inference.
// ---------------------------------------------------------------------------
interface nn_frame_packer_if
    import nn_pkg::*;
#(
    parameter int NI = nn_pkg::NI,
    parameter int PW = nn_pkg::PW,
    parameter int CW = nn_pkg::CW
);

    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          pix_last;
    logic          pix_ready;

    logic [NI-1:0] nn_xi;
    logic          nn_start;
    logic          nn_ack;
    logic          nn_done;
    logic [CW-1:0] nn_yi;

    logic          res_valid;
    logic [CW-1:0] res_class;
    logic          res_ready;

    logic          frame_err;

`ifdef NN_FRAME_PACKER_LATCNT_EN
    logic [15:0]   lat_cycles;
`endif

    modport master (
        input  pix_valid, pix_data, pix_last, nn_ack, nn_done, nn_yi, res_ready,
`ifdef NN_FRAME_PACKER_LATCNT_EN
        output lat_cycles,
`endif
        output pix_ready, nn_xi, nn_start, res_valid, res_class, frame_err
    );

    modport slave (
        output pix_valid, pix_data, pix_last, nn_ack, nn_done, nn_yi, res_ready,
`ifdef NN_FRAME_PACKER_LATCNT_EN
        input  lat_cycles,
`endif
        input  pix_ready, nn_xi, nn_start, res_valid, res_class, frame_err
    );

endinterface

// File: rtl/nn_pix_shreg.sv
// ---------------------------------------------------------------------------
// nn_pix_shreg
// Binarises each accepted pixel against THRESH and shifts the bit into an
// NI-bit register, MSB-first, so the first pixel of a frame ends up in
// xi[NI-1]. A beat counter checks the frame length against pix_last.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   beat        a pixel transfers this cycle
//   pix_data    grayscale pixel
//   pix_last    beat marks the final pixel of a frame
//   xi          packed binary frame
//   frame_full  strobe: beat completes a well-formed NI-pixel frame
//   err         strobe: beat reveals a short or long frame
// ---------------------------------------------------------------------------
module nn_pix_shreg
    import nn_pkg::*;
#(
    parameter int NI     = nn_pkg::NI,
    parameter int PW     = nn_pkg::PW,
    parameter int THRESH = nn_pkg::THRESH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          beat,
    input  logic [PW-1:0] pix_data,
    input  logic          pix_last,
    output logic [NI-1:0] xi,
    output logic          frame_full,
    output logic          err
);

    localparam int CNTW = $clog2(NI);

    logic [CNTW-1:0] pix_cnt;
    logic            pix_bit;
    logic            at_end;

    assign pix_bit = (pix_data >= PW'(THRESH));
    assign at_end  = (pix_cnt == CNTW'(NI - 1));

    // A frame is good only when pix_last and the final count coincide; either
    // one arriving alone marks the frame as malformed.
    assign frame_full = beat && pix_last && at_end;
    assign err        = beat && (pix_last ^ at_end);

    // Shift register and beat counter. The counter restarts at every frame
    // boundary, good or bad, so the next beat always opens a fresh frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            xi      <= '0;
            pix_cnt <= '0;
        end else if (beat) begin
            xi <= {xi[NI-2:0], pix_bit};
            if (pix_last || at_end) begin
                pix_cnt <= '0;
            end else begin
                pix_cnt <= pix_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: rtl/nn_frame_packer.sv
// ---------------------------------------------------------------------------
// nn_frame_packer
// Front-end of the nn inference core: collects one 16x16 frame of 8-bit
// pixels, binarises and packs it into nn_xi, runs the start/ack/done
// handshake with the core and presents the predicted class on a
// valid/ready result interface.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       nn_frame_packer_if.master: pixel stream, nn core handshake,
//             result interface and the frame_err pulse
// Optional macro NN_FRAME_PACKER_LATCNT_EN adds bus.lat_cycles, counting
// cycles from nn_start assertion to nn_done sampling (saturating at FFFF).
// Pixels are stalled for the whole START/WAIT_DONE/RESULT period, which
// keeps nn_xi stable while the core reads it.
// ---------------------------------------------------------------------------
module nn_frame_packer
    import nn_pkg::*;
#(
    parameter int NI     = nn_pkg::NI,
    parameter int PW     = nn_pkg::PW,
    parameter int CW     = nn_pkg::CW,
    parameter int THRESH = nn_pkg::THRESH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    nn_frame_packer_if.master  bus
);

    state_t        state;
    state_t        state_next;
    logic          ready_q;
    logic          beat;
    logic          frame_full;
    logic          shreg_err;
    logic          frame_err_q;
    logic [CW-1:0] class_q;

    assign beat = bus.pix_valid && bus.pix_ready;

    nn_pix_shreg #(
        .NI     (NI),
        .PW     (PW),
        .THRESH (THRESH)
    ) u_shreg (
        .clk        (clk),
        .rst        (rst),
        .beat       (beat),
        .pix_data   (bus.pix_data),
        .pix_last   (bus.pix_last),
        .xi         (bus.nn_xi),
        .frame_full (frame_full),
        .err        (shreg_err)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. ack and done only matter in their own states, so a
    // stray pulse elsewhere is ignored; done already high on WAIT_DONE entry
    // is accepted on the first WAIT_DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            FILL:      if (frame_full)    state_next = START;
            START:     if (bus.nn_ack)    state_next = WAIT_DONE;
            WAIT_DONE: if (bus.nn_done)   state_next = RESULT;
            RESULT:    if (bus.res_ready) state_next = FILL;
            default:                      state_next = FILL;
        endcase
    end

    // Decoded outputs. ready_q holds pix_ready low during reset and for the
    // edge that releases it, so pixels are accepted only once the packer is
    // truly out of reset.
    always_comb begin
        bus.pix_ready = (state == FILL) && ready_q;
        bus.nn_start  = (state == START);
        bus.res_valid = (state == RESULT);
        bus.res_class = class_q;
        bus.frame_err = frame_err_q;
    end

    // Registered outputs: the class is captured on the done edge and held
    // through RESULT; frame_err is a one-cycle echo of the shifter's error
    // strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q     <= 1'b0;
            frame_err_q <= 1'b0;
            class_q     <= '0;
        end else begin
            ready_q     <= 1'b1;
            frame_err_q <= shreg_err;
            if (state == WAIT_DONE && bus.nn_done) begin
                class_q <= bus.nn_yi;
            end
        end
    end

`ifdef NN_FRAME_PACKER_LATCNT_EN
    logic [15:0] lat_q;

    // Latency counter: cleared when the frame completes (START entry) and
    // advanced every cycle spent in START or WAIT_DONE, including the cycle
    // in which done is sampled; it then holds through RESULT and FILL.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_q <= '0;
        end else if (frame_full) begin
            lat_q <= '0;
        end else if ((state == START || state == WAIT_DONE) && lat_q != 16'hFFFF) begin
            lat_q <= lat_q + 16'd1;
        end
    end

    assign bus.lat_cycles = lat_q;
`endif

endmodule

// File: tb/tb_nn_frame_packer.sv
// ---------------------------------------------------------------------------
// tb_nn_frame_packer
// Directed bench for nn_frame_packer: full frames of several pixel patterns,
// threshold edge values, short and long frames, delayed ack/done/ready and a
// reset in WAIT_DONE. Expected values are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_nn_frame_packer;
    import nn_pkg::*;

    localparam logic [255:0] XI_ONES  = {256{1'b1}};
    localparam logic [255:0] XI_ZERO  = {256{1'b0}};
    localparam logic [255:0] XI_ALT10 = {128{2'b10}};
    localparam logic [255:0] XI_ALT01 = {128{2'b01}};
    localparam logic [255:0] XI_HALF  = {{128{1'b1}}, {128{1'b0}}};

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    nn_frame_packer_if bus ();

    nn_frame_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Single comparison point; every check in the bench comes through here.
    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] pixOf(input int pat, input int i);
        case (pat)
            0:       return 8'hFF;
            1:       return (i % 2 == 0) ? 8'd200 : 8'd50;
            2:       return (i % 2 == 0) ? 8'd127 : 8'd128;
            3:       return (i < 128) ? 8'd128 : 8'd0;
            default: return 8'd50;
        endcase
    endfunction

    // Present one pixel beat and hold it until the packer accepts it.
    task automatic applyStimulus(input logic [7:0] data, input logic last);
        int w;
        @(negedge clk);
        bus.pix_valid = 1'b1;
        bus.pix_data  = data;
        bus.pix_last  = last;
        w = 0;
        while (!bus.pix_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) checkOutput("pix_ready_wait", 1'b0, 1'b1);
        @(posedge clk);
    endtask

    // n beats of pattern pat; pix_last on beat index lastIdx (-1: none).
    task automatic sendFrame(input int pat, input int n, input int lastIdx);
        for (int i = 0; i < n; i++) begin
            applyStimulus(pixOf(pat, i), (i == lastIdx));
        end
    endtask

    // Plays the nn core right after a frame's last beat. Cycle c counts from
    // the first cycle nn_start should be high; ack is sampled at the edge
    // ending cycle ackDelay-1, done at the edge ending cycle doneEdge-1
    // (or, with doneHold, done stays high from cycle 0).
    task automatic runNn(input logic [255:0] expXi, input int ackDelay, input int doneEdge,
                         input bit doneHold, input logic [3:0] yi, input int readyDelay);
        int resEdge;
        resEdge = doneHold ? ackDelay + 1 : doneEdge;
        for (int c = 0; c < resEdge; c++) begin
            @(negedge clk);
            bus.pix_valid = 1'b0;
            bus.pix_last  = 1'b0;
            if (c == 0) checkOutput("nn_xi", bus.nn_xi, expXi);
            checkOutput("nn_start", bus.nn_start, (c < ackDelay));
            checkOutput("pix_ready_busy", bus.pix_ready, 1'b0);
            checkOutput("res_valid_busy", bus.res_valid, 1'b0);
            bus.nn_ack  = (c == ackDelay - 1);
            bus.nn_done = doneHold || (c == doneEdge - 1);
            bus.nn_yi   = bus.nn_done ? yi : 4'd15;
        end
        @(negedge clk);
        bus.nn_ack  = 1'b0;
        bus.nn_done = 1'b0;
        bus.nn_yi   = 4'd15;
        checkOutput("res_valid", bus.res_valid, 1'b1);
        checkOutput("res_class", bus.res_class, yi);
        checkOutput("nn_start_off", bus.nn_start, 1'b0);
        checkOutput("nn_xi_hold", bus.nn_xi, expXi);
`ifdef NN_FRAME_PACKER_LATCNT_EN
        checkOutput("lat_cycles", bus.lat_cycles, resEdge);
`endif
        for (int r = 0; r < readyDelay; r++) begin
            @(negedge clk);
            checkOutput("res_valid_hold", bus.res_valid, 1'b1);
            checkOutput("res_class_hold", bus.res_class, yi);
            checkOutput("pix_ready_result", bus.pix_ready, 1'b0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checkOutput("res_valid_clear", bus.res_valid, 1'b0);
        checkOutput("pix_ready_back", bus.pix_ready, 1'b1);
    endtask

    // After a malformed frame: one-cycle frame_err, no start, still filling.
    task automatic checkDropped(input string tag);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        checkOutput({tag, "_err"}, bus.frame_err, 1'b1);
        checkOutput({tag, "_nostart"}, bus.nn_start, 1'b0);
        checkOutput({tag, "_ready"}, bus.pix_ready, 1'b1);
        @(negedge clk);
        checkOutput({tag, "_err_pulse"}, bus.frame_err, 1'b0);
        checkOutput({tag, "_nostart2"}, bus.nn_start, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_data  = '0;
        bus.pix_last  = 1'b0;
        bus.nn_ack    = 1'b0;
        bus.nn_done   = 1'b0;
        bus.nn_yi     = 4'd15;
        bus.res_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("rst_pix_ready", bus.pix_ready, 1'b0);
        checkOutput("rst_nn_xi", bus.nn_xi, XI_ZERO);
        checkOutput("rst_nn_start", bus.nn_start, 1'b0);
        checkOutput("rst_res_valid", bus.res_valid, 1'b0);
        checkOutput("rst_res_class", bus.res_class, 4'd0);
        checkOutput("rst_frame_err", bus.frame_err, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_release_ready", bus.pix_ready, 1'b1);

        $display("[TB] all-ones frame, fast core");
        sendFrame(0, 256, 255);
        runNn(XI_ONES, 1, 2, 1'b0, 4'd7, 0);

        $display("[TB] alternating 200/50, ack after 5, done 40 later, ready after 3");
        sendFrame(1, 256, 255);
        runNn(XI_ALT10, 5, 45, 1'b0, 4'd3, 3);

        $display("[TB] threshold edge 127/128, done held high before ack");
        sendFrame(2, 256, 255);
        runNn(XI_ALT01, 2, 0, 1'b1, 4'd9, 1);

        $display("[TB] short frame of 100 beats then clean frame");
        sendFrame(3, 100, 99);
        checkDropped("short");
        sendFrame(3, 256, 255);
        runNn(XI_HALF, 3, 10, 1'b0, 4'd0, 2);

        $display("[TB] long frame without pix_last then clean frame");
        sendFrame(0, 256, -1);
        checkDropped("long");
        sendFrame(4, 256, 255);
        runNn(XI_ZERO, 1, 3, 1'b0, 4'd6, 0);

        $display("[TB] reset during WAIT_DONE");
        sendFrame(0, 256, 255);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        checkOutput("mid_start", bus.nn_start, 1'b1);
        bus.nn_ack = 1'b1;
        @(negedge clk);
        bus.nn_ack = 1'b0;
        checkOutput("mid_wait_start", bus.nn_start, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        bus.nn_done = 1'b1;
        bus.nn_yi   = 4'd2;
        checkOutput("mid_rst_start", bus.nn_start, 1'b0);
        checkOutput("mid_rst_valid", bus.res_valid, 1'b0);
        checkOutput("mid_rst_ready", bus.pix_ready, 1'b0);
        checkOutput("mid_rst_class", bus.res_class, 4'd0);
        checkOutput("mid_rst_xi", bus.nn_xi, XI_ZERO);
        checkOutput("mid_rst_cnt", dut.u_shreg.pix_cnt, 8'd0);
        @(negedge clk);
        bus.nn_done = 1'b0;
        bus.nn_yi   = 4'd15;
        checkOutput("late_done_ignored", bus.res_valid, 1'b0);
        checkOutput("late_done_class", bus.res_class, 4'd0);
        checkOutput("post_rst_ready", bus.pix_ready, 1'b1);
        sendFrame(1, 256, 255);
        runNn(XI_ALT10, 4, 7, 1'b0, 4'd5, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
